// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
//  Module      : pipeline_hazard_ctrl_if
//  Description : Decoded-field and control bundle between the pipeline
//                datapath (master) and the hazard controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    // Decoded fields from ID / EX / MEM / WB
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic             ex_wreg;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_redirect;
    logic             mem_wreg;
    logic             wb_wreg;
    logic [4:0]       mem_rd;
    logic [4:0]       wb_rd;
    logic             mem_busy;

    // Pipeline control back to the datapath
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             pc_redirect;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             mem_wb_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_rs, ex_rt, ex_wreg,
               ex_mem_read, ex_rd, ex_redirect, mem_wreg, wb_wreg, mem_rd,
               wb_rd, mem_busy,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, pc_redirect,
               if_id_flush, id_ex_bubble, mem_wb_bubble, fwd_a, fwd_b,
               mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rs, ex_rt, ex_wreg,
               ex_mem_read, ex_rd, ex_redirect, mem_wreg, wb_wreg, mem_rd,
               wb_rd, mem_busy,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, pc_redirect,
               if_id_flush, id_ex_bubble, mem_wb_bubble, fwd_a, fwd_b,
               mem_err, stall_cnt, flush_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Stall / flush / forward scheduler for a 5-stage pipeline.
//                Handles data-memory wait freeze with timeout, multi-cycle
//                IF/ID flush after an EX redirect, load-use stalls and EX
//                operand forwarding. Keeps saturating stall/flush counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,    // 1..7
    parameter int MEM_TIMEOUT  = 255,  // 1..255
    parameter int CNT_W        = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_LIMIT   = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       flush_ctr;
    logic [2:0]       flush_ctr_nxt;
    logic [7:0]       wait_ctr;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             stall_evt;
    logic             flush_evt;
    logic             in_flush;
    logic             load_use;

    // A frozen FLUSH keeps its counter, so leaving MEM_WAIT with a nonzero
    // count behaves as FLUSH in that same cycle.
    assign in_flush = (state == FLUSH) ||
                      ((state == MEM_WAIT) && (flush_ctr != 3'd0));

    assign load_use = hz.ex_mem_read && hz.ex_wreg && (hz.ex_rd != 5'd0) &&
                      ((hz.id_use_rs && (hz.id_rs == hz.ex_rd)) ||
                       (hz.id_use_rt && (hz.id_rt == hz.ex_rd)));

    // State and flush-counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            flush_ctr <= 3'd0;
        end else begin
            state     <= state_nxt;
            flush_ctr <= flush_ctr_nxt;
        end
    end

    // Next state and pipeline controls; priority busy > redirect > load-use
    always_comb begin
        state_nxt         = state;
        flush_ctr_nxt     = flush_ctr;
        stall_evt         = 1'b0;
        flush_evt         = 1'b0;
        hz.pc_en          = 1'b1;
        hz.if_id_en       = 1'b1;
        hz.id_ex_en       = 1'b1;
        hz.ex_mem_en      = 1'b1;
        hz.pc_redirect    = 1'b0;
        hz.if_id_flush    = 1'b0;
        hz.id_ex_bubble   = 1'b0;
        hz.mem_wb_bubble  = 1'b0;

        if (hz.mem_busy) begin
            hz.pc_en         = 1'b0;
            hz.if_id_en      = 1'b0;
            hz.id_ex_en      = 1'b0;
            hz.ex_mem_en     = 1'b0;
            hz.mem_wb_bubble = 1'b1;
            state_nxt        = MEM_WAIT;
        end else if (hz.ex_redirect) begin
            hz.pc_redirect  = 1'b1;
            hz.if_id_flush  = 1'b1;
            hz.id_ex_bubble = 1'b1;
            flush_evt       = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                flush_ctr_nxt = FLUSH_RELOAD;
                state_nxt     = FLUSH;
            end else begin
                flush_ctr_nxt = 3'd0;
                state_nxt     = RUN;
            end
        end else if (in_flush) begin
            // Flushing IF/ID already discards the dependent instruction,
            // so a load-use match here needs no stall.
            hz.if_id_flush = 1'b1;
            flush_ctr_nxt  = flush_ctr - 3'd1;
            state_nxt      = (flush_ctr == 3'd1) ? RUN : FLUSH;
        end else begin
            state_nxt = RUN;
            if (load_use) begin
                hz.pc_en        = 1'b0;
                hz.if_id_en     = 1'b0;
                hz.id_ex_bubble = 1'b1;
                stall_evt       = 1'b1;
            end
        end

        // Reset holds the pipeline frozen and bubbled independent of clk
        if (!rst_n) begin
            hz.pc_en         = 1'b0;
            hz.if_id_en      = 1'b0;
            hz.id_ex_en      = 1'b0;
            hz.ex_mem_en     = 1'b0;
            hz.pc_redirect   = 1'b0;
            hz.if_id_flush   = 1'b1;
            hz.id_ex_bubble  = 1'b1;
            hz.mem_wb_bubble = 1'b1;
        end
    end

    // Memory wait counter and sticky timeout flag; every frozen cycle counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_ctr <= 8'd0;
            mem_err  <= 1'b0;
        end else if (hz.mem_busy) begin
            if (wait_ctr != WAIT_LIMIT) begin
                wait_ctr <= wait_ctr + 8'd1;
            end
            if (wait_ctr == (WAIT_LIMIT - 8'd1)) begin
                mem_err <= 1'b1;
            end
        end else begin
            wait_ctr <= 8'd0;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_evt && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    // Operand forwarding: MEM beats WB, register 0 never forwarded
    always_comb begin
        hz.fwd_a = 2'b00;
        hz.fwd_b = 2'b00;
        if (hz.mem_wreg && (hz.mem_rd != 5'd0) && (hz.mem_rd == hz.ex_rs)) begin
            hz.fwd_a = 2'b10;
        end else if (hz.wb_wreg && (hz.wb_rd != 5'd0) && (hz.wb_rd == hz.ex_rs)) begin
            hz.fwd_a = 2'b01;
        end
        if (hz.mem_wreg && (hz.mem_rd != 5'd0) && (hz.mem_rd == hz.ex_rt)) begin
            hz.fwd_b = 2'b10;
        end else if (hz.wb_wreg && (hz.wb_rd != 5'd0) && (hz.wb_rd == hz.ex_rt)) begin
            hz.fwd_b = 2'b01;
        end
        if (!rst_n) begin
            hz.fwd_a = 2'b00;
            hz.fwd_b = 2'b00;
        end
    end

    assign hz.mem_err   = mem_err;
    assign hz.stall_cnt = stall_cnt;
    assign hz.flush_cnt = flush_cnt;

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/forward scheduler for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Decides every cycle which pipeline registers advance, which are bubbled or flushed, and where EX operands come from.
- Sequences multi-cycle events: data-memory wait, and multi-cycle redirect flush after a taken branch or jump resolved in EX.
- Sits beside the decoder; consumes decoded register and usage fields from ID, EX, MEM and WB.

Parameters:
FLUSH_CYCLES, 1, cycles IF/ID is flushed per redirect (redirect cycle included); legal 1..7.
MEM_TIMEOUT, 255, MEM_WAIT cycles before mem_err is raised; legal 1..255.
CNT_W, 16, width of the saturating performance counters.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_rs, id_rt  in  5 each  source registers of the instruction in ID
id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt
ex_rs, ex_rt  in  5 each  source registers of the instruction in EX
ex_wreg, ex_mem_read  in  1 each  EX instruction writes a register / is a load
ex_rd  in  5  destination register of EX
ex_redirect  in  1  EX resolved a taken branch, jump or jr
mem_wreg, wb_wreg  in  1 each  MEM / WB stage writes a register
mem_rd, wb_rd  in  5 each  destination registers of MEM / WB
mem_busy  in  1  data memory not ready this cycle
pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register advance enables
pc_redirect  out  1  PC mux selects the EX target
if_id_flush, id_ex_bubble, mem_wb_bubble  out  1 each  insert NOP into the named register
fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 10 MEM, 01 WB
mem_err  out  1  sticky memory-timeout flag
stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset (rst_n low, asynchronous):
  - State returns to RUN; flush counter, wait counter, mem_err, stall_cnt and flush_cnt clear to 0 immediately.
  - While reset is asserted, all enables = 0, pc_redirect = 0, if_id_flush = id_ex_bubble = mem_wb_bubble = 1, fwd = 00.
- FSM states: RUN, MEM_WAIT, FLUSH. Control outputs are combinational from state and inputs; counters and state are registered.
- Priority within a cycle: mem_busy > ex_redirect > load-use hazard.
- mem_busy = 1 (any state):
  - All enables = 0; mem_wb_bubble = 1; if_id_flush = id_ex_bubble = pc_redirect = 0.
  - Next state MEM_WAIT. The flush counter holds, so a FLUSH in progress resumes afterwards.
  - Wait counter increments each MEM_WAIT cycle and saturates at MEM_TIMEOUT.
  - mem_err sets when the counter reaches MEM_TIMEOUT and stays set until reset. The freeze continues regardless.
- MEM_WAIT with mem_busy = 0:
  - Wait counter clears. Next state is FLUSH if the flush counter is nonzero, else RUN.
  - That same cycle is evaluated as RUN/FLUSH rules.
- ex_redirect = 1 (not busy):
  - pc_redirect = 1, if_id_flush = 1, id_ex_bubble = 1; all enables = 1.
  - flush_cnt += 1.
  - If FLUSH_CYCLES > 1: load the flush counter with FLUSH_CYCLES-1 and go to FLUSH.
- FLUSH (not busy, no new redirect):
  - if_id_flush = 1, all enables = 1, flush counter decrements; go to RUN when it reaches 0.
  - A new ex_redirect in FLUSH reloads the counter.
- Load-use hazard (RUN or FLUSH, not busy, no redirect):
  - Condition: ex_mem_read & ex_wreg & ex_rd != 0 & ((id_use_rs & id_rs == ex_rd) | (id_use_rt & id_rt == ex_rd)).
  - Response: pc_en = if_id_en = 0, id_ex_bubble = 1, ex_mem_en = 1; stall_cnt += 1.
  - Lasts exactly one cycle per hazard; the load then sits in MEM and forwarding covers it.
  - In FLUSH, if_id_flush wins over the hazard: no stall, and stall_cnt does not count.
- Normal RUN: all enables = 1; bubbles, flush and pc_redirect = 0.
- Forwarding (combinational, independent of state, rst_n aside):
  - fwd_a = 10 if mem_wreg & mem_rd != 0 & mem_rd == ex_rs; else 01 if wb_wreg & wb_rd != 0 & wb_rd == ex_rs; else 00. fwd_b is the same using ex_rt.
  - MEM beats WB.
  - Register 0 is never forwarded.
- Counters saturate at all-ones and never wrap.

Test Plan:
- Load-use: ex_mem_read = ex_wreg = 1, ex_rd = 5, id_rs = 5, id_use_rs = 1 for one cycle -> that cycle pc_en = if_id_en = 0, id_ex_bubble = 1; next cycle (ex_mem_read = 0) all enables = 1; stall_cnt = 1. Repeat with ex_rd = 0 -> no stall.
- Forwarding: mem_rd = wb_rd = 7, both wreg, ex_rs = 7 -> fwd_a = 10. mem_wreg = 0 -> 01. ex_rs = 0 with mem_rd = 0 -> 00. ex_rt = 9 = wb_rd -> fwd_b = 01.
- Redirect with FLUSH_CYCLES = 3: one-cycle ex_redirect -> pc_redirect high 1 cycle; if_id_flush high 3 consecutive cycles; flush_cnt = 1. Second redirect on cycle 2 -> flush extended to cycle 4.
- Memory wait: mem_busy high 3 cycles coincident with ex_redirect and a load-use match -> 3 cycles of all enables = 0, mem_wb_bubble = 1, no redirect. On cycle 4 redirect applies (pc_redirect = 1) and no stall is counted.
- Timeout with MEM_TIMEOUT = 4: mem_busy held 6 cycles -> mem_err rises after the 4th MEM_WAIT cycle, stays high after busy drops, freeze lasts all 6 cycles.
- Asynchronous reset asserted mid-FLUSH between clock edges -> state RUN, counters 0, mem_err 0, bubbles/flush forced 1 without waiting for clk; after release, normal RUN.
